// File: rtl/w_grf_writeback_pkg.sv
// Shared register-file constants: index width, the $0/$ra indices and the RegDst encodings.
// Both the E-stage destination mux and the register file use these values.
package w_grf_writeback_pkg;

    localparam int GRF_AW = 5;
    localparam logic [GRF_AW-1:0] GRF_ZERO = 5'd0;
    localparam logic [GRF_AW-1:0] GRF_RA   = 5'd31;

    // Destination-register select driven by the E stage.
    typedef enum logic [1:0] {
        REGDST_RT    = 2'd0,
        REGDST_RD    = 2'd1,
        REGDST_GRF31 = 2'd2
    } regdst_t;

endpackage

// File: rtl/w_grf_writeback_read_port.sv
// One combinational GRF read port: $0 forced to zero, optional same-cycle W->D forwarding.
// Latency 0 (pure combinational); no backpressure.
module w_grf_writeback_read_port #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter bit BYPASS = 1'b0
) (
    input  logic [AW-1:0] idx,
    input  logic [DW-1:0] row,
    input  logic [AW-1:0] w_a3,
    input  logic [DW-1:0] w_wd,
    input  logic          w_we,
    output logic [DW-1:0] data
);

    logic byp_hit;

    // A cancelled write (w_a3 == 0) must never be forwarded.
    assign byp_hit = BYPASS && w_we && (w_a3 != '0) && (w_a3 == idx);

    assign data = (idx == '0) ? '0 :
                  byp_hit     ? w_wd : row;

endmodule

// File: rtl/w_grf_writeback.sv
// 32x32 register file sinking W-stage writeback and serving two D-stage reads; build option GRF_WRITE_BYPASS_EN.
// Write latency 1 cycle, reads combinational (0 cycles with bypass, 1 cycle visibility without).
// No backpressure: every write is accepted; W_A3 == 0 is a cancelled write.
module w_grf_writeback
    import w_grf_writeback_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = GRF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] D_A1,
    input  logic [AW-1:0] D_A2,
    output logic [DW-1:0] D_RD1,
    output logic [DW-1:0] D_RD2,
    input  logic [AW-1:0] W_A3,
    input  logic [DW-1:0] W_WD,
    input  logic          W_WE,
    input  logic [31:0]   W_PC
);

    localparam int NREG = 2**AW;

`ifdef GRF_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DW-1:0] rf [0:NREG-1];
    logic          wr_commit;

    assign wr_commit = W_WE && (W_A3 != AW'(GRF_ZERO));

    // Reset wins over a coincident write, which is dropped without a trace line.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_commit) begin
            rf[W_A3] <= W_WD;
`ifndef SYNTHESIS
            $display("@%h: $%d <= %h", W_PC, W_A3, W_WD);
`endif
        end
    end

    w_grf_writeback_read_port #(.DW(DW), .AW(AW), .BYPASS(BYPASS)) u_rd1 (
        .idx  (D_A1),
        .row  (rf[D_A1]),
        .w_a3 (W_A3),
        .w_wd (W_WD),
        .w_we (W_WE),
        .data (D_RD1)
    );

    w_grf_writeback_read_port #(.DW(DW), .AW(AW), .BYPASS(BYPASS)) u_rd2 (
        .idx  (D_A2),
        .row  (rf[D_A2]),
        .w_a3 (W_A3),
        .w_wd (W_WD),
        .w_we (W_WE),
        .data (D_RD2)
    );

endmodule

// File: tb/tb_w_grf_writeback.sv
// Directed bench for w_grf_writeback: a vector table plus hand-written reset/back-to-back sequences.
module tb_w_grf_writeback;

`ifdef GRF_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_A1, D_A2, W_A3;
    logic [31:0] D_RD1, D_RD2, W_WD, W_PC;
    logic        W_WE;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    w_grf_writeback dut (
        .clk   (clk),
        .reset (reset),
        .D_A1  (D_A1),
        .D_A2  (D_A2),
        .D_RD1 (D_RD1),
        .D_RD2 (D_RD2),
        .W_A3  (W_A3),
        .W_WD  (W_WD),
        .W_WE  (W_WE),
        .W_PC  (W_PC)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        chk;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vt [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs sampled 2 time units later, before the next rising edge.
    task automatic drive(input logic rst, input logic we, input logic [4:0] a3,
                         input logic [31:0] wd, input logic [31:0] pc,
                         input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        reset = rst; W_WE = we; W_A3 = a3; W_WD = wd; W_PC = pc;
        D_A1 = a1; D_A2 = a2;
        #2;
    endtask

    initial begin
        reset = 1'b1; W_WE = 1'b0; W_A3 = '0; W_WD = '0; W_PC = '0; D_A1 = '0; D_A2 = '0;

        //        rst   we    a3     wd             pc          a1     a2     chk   e1                          e2
        vt[0] = '{1'b1, 1'b0, 5'd0,  32'h0,         32'h0,      5'd5,  5'd31, 1'b0, 32'h0,                      32'h0};
        vt[1] = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0,      5'd5,  5'd31, 1'b1, 32'h0,                      32'h0};
        vt[2] = '{1'b0, 1'b1, 5'd8,  32'h1234_5678, 32'h3000,   5'd8,  5'd0,  1'b1, BYP ? 32'h1234_5678 : 32'h0, 32'h0};
        vt[3] = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0,      5'd8,  5'd5,  1'b1, 32'h1234_5678,              32'h0};
        vt[4] = '{1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 32'h3004,   5'd0,  5'd8,  1'b1, 32'h0,                      32'h1234_5678};
        vt[5] = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0,      5'd0,  5'd8,  1'b1, 32'h0,                      32'h1234_5678};
        vt[6] = '{1'b0, 1'b1, 5'd9,  32'h0000_ABCD, 32'h3008,   5'd9,  5'd9,  1'b1, BYP ? 32'hABCD : 32'h0,     BYP ? 32'hABCD : 32'h0};
        vt[7] = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0,      5'd9,  5'd9,  1'b1, 32'hABCD,                   32'hABCD};
        vt[8] = '{1'b0, 1'b0, 5'd10, 32'h55,        32'h300C,   5'd10, 5'd10, 1'b1, 32'h0,                      32'h0};
        vt[9] = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0,      5'd10, 5'd8,  1'b1, 32'h0,                      32'h1234_5678};

        for (int v = 0; v < 10; v++) begin
            drive(vt[v].rst, vt[v].we, vt[v].a3, vt[v].wd, vt[v].pc, vt[v].a1, vt[v].a2);
            if (vt[v].chk) begin
                check($sformatf("vec%0d_rd1", v), D_RD1, vt[v].e1);
                check($sformatf("vec%0d_rd2", v), D_RD2, vt[v].e2);
            end
        end

        // Preload $1..$31 with their own index.
        for (int r = 1; r < 32; r++) begin
            drive(1'b0, 1'b1, 5'(r), 32'(r), 32'h4000 + 32'(r * 4), 5'd0, 5'd0);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd31, 5'd17);
        check("preload_r31", D_RD1, 32'd31);
        check("preload_r17", D_RD2, 32'd17);

        // Reset together with a write to $31: the write is discarded.
        drive(1'b1, 1'b1, 5'd31, 32'd7, 32'h5000, 5'd31, 5'd1);
        check("rst_bypass_r31", D_RD1, BYP ? 32'd7 : 32'd31);
        for (int r = 0; r < 32; r++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(r), 5'(31 - r));
            check($sformatf("post_rst_p1_r%0d", r), D_RD1, 32'h0);
            check($sformatf("post_rst_p2_r%0d", 31 - r), D_RD2, 32'h0);
        end

        // Back-to-back writes to the link register.
        drive(1'b0, 1'b1, 5'd31, 32'd1, 32'h6000, 5'd31, 5'd31);
        check("b2b_w1_rd1", D_RD1, BYP ? 32'd1 : 32'd0);
        drive(1'b0, 1'b1, 5'd31, 32'd2, 32'h6004, 5'd31, 5'd30);
        check("b2b_w2_rd1", D_RD1, BYP ? 32'd2 : 32'd1);
        check("b2b_w2_rd2", D_RD2, 32'd0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd31, 5'd31);
        check("b2b_final_rd1", D_RD1, 32'd2);
        check("b2b_final_rd2", D_RD2, 32'd2);

        // Attempted write to $0 with full data must not leak into reads.
        drive(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'h7000, 5'd0, 5'd0);
        check("zero_wr_same", D_RD1, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd31);
        check("zero_wr_after", D_RD1, 32'h0);
        check("zero_wr_r31", D_RD2, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
